// File: rtl/board_move_ctrl.sv
// board_move_ctrl: game-state sequencer for the chess display.
// Runs the select-source / select-destination move flow from the cursor and
// the Enter/Esc buttons. It scans the piece slots one per cycle and commits
// each move at a frame boundary, so the renderer never sees a half-updated
// board. There is no legality checking; the block only handles own-piece
// blocking and capture bookkeeping.
// Optional feature macro: SELECT_TIMEOUT_EN. When it is defined, a held
// selection is cancelled after TIMEOUT_FRAMES frames.
module board_move_ctrl #(
    parameter int NUM_PIECES     = 16,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic                    clk12,
    input  logic                    reset,
    input  logic [5:0]              cursor,
    input  logic                    btn_enter,
    input  logic                    btn_esc,
    input  logic                    frame_start,
    output logic [6*NUM_PIECES-1:0] location_vectors_w,
    output logic [6*NUM_PIECES-1:0] location_vectors_b,
    output logic [NUM_PIECES-1:0]   alive_vectors_w,
    output logic [NUM_PIECES-1:0]   alive_vectors_b,
    output logic                    player,
    output logic                    sel_active,
    output logic [5:0]              sel_square,
    output logic                    move_done,
    output logic                    move_reject
);

    localparam int LW = 6 * NUM_PIECES;
    localparam int KW = $clog2(NUM_PIECES);

    // Starting position: white on rows 0-1, black on rows 6-7.
    localparam logic [LW-1:0] RST_LOC_W = 96'h20928B30D38F0070460850C4;
    localparam logic [LW-1:0] RST_LOC_B = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCAN_SRC   = 3'd1,
        S_SELECTED   = 3'd2,
        S_SCAN_DST   = 3'd3,
        S_WAIT_FRAME = 3'd4,
        S_COMMIT     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  enter_prev_q;
    logic                  esc_prev_q;
    logic [5:0]            src_sq_q, src_sq_d;
    logic [5:0]            dst_sq_q, dst_sq_d;
    logic [KW-1:0]         k_q, k_d;
    logic [KW-1:0]         src_idx_q, src_idx_d;
    logic [KW-1:0]         cap_idx_q, cap_idx_d;
    logic                  cap_valid_q, cap_valid_d;
    logic                  own_block_q, own_block_d;
    logic [LW-1:0]         loc_w_q, loc_w_d;
    logic [LW-1:0]         loc_b_q, loc_b_d;
    logic [NUM_PIECES-1:0] alive_w_q, alive_w_d;
    logic [NUM_PIECES-1:0] alive_b_q, alive_b_d;
    logic                  player_q, player_d;
    logic                  sel_active_q, sel_active_d;
    logic [5:0]            sel_square_q, sel_square_d;
    logic                  move_done_q, move_done_d;
    logic                  move_reject_q, move_reject_d;

    logic                  enter_p_s;
    logic                  esc_p_s;
    logic [LW-1:0]         own_loc_s;
    logic [LW-1:0]         opp_loc_s;
    logic [NUM_PIECES-1:0] own_alive_s;
    logic [NUM_PIECES-1:0] opp_alive_s;
    logic [5:0]            scan_sq_s;
    logic                  own_hit_s;
    logic                  opp_hit_s;
    logic                  k_last_s;
    logic                  timeout_s;

    // Button edges; Esc wins over a simultaneous Enter.
    assign esc_p_s   = btn_esc & ~esc_prev_q;
    assign enter_p_s = btn_enter & ~enter_prev_q & ~esc_p_s;

    // The side to move owns the "own" vectors; the other side can be captured.
    assign own_loc_s   = player_q ? loc_b_q   : loc_w_q;
    assign opp_loc_s   = player_q ? loc_w_q   : loc_b_q;
    assign own_alive_s = player_q ? alive_b_q : alive_w_q;
    assign opp_alive_s = player_q ? alive_w_q : alive_b_q;
    assign scan_sq_s   = (state_q == S_SCAN_SRC) ? src_sq_q : dst_sq_q;
    assign own_hit_s   = own_alive_s[k_q] && (own_loc_s[int'(k_q)*6 +: 6] == scan_sq_s);
    assign opp_hit_s   = opp_alive_s[k_q] && (opp_loc_s[int'(k_q)*6 +: 6] == scan_sq_s);
    assign k_last_s    = (k_q == KW'(NUM_PIECES - 1));

`ifdef SELECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    logic [TW-1:0] frame_cnt_q, frame_cnt_d;

    assign timeout_s = frame_start && ((frame_cnt_q + TW'(1)) == TW'(TIMEOUT_FRAMES));

    // Frame counter: counts frames only while a selection is held.
    always_comb begin
        frame_cnt_d = '0;
        if (state_q == S_SELECTED) begin
            if (frame_start) begin
                frame_cnt_d = frame_cnt_q + TW'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            frame_cnt_d = '0;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk12) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    // A selection never times out. TIMEOUT_FRAMES is positive, so this is constant zero.
    assign timeout_s = (TIMEOUT_FRAMES < 0);
`endif

    // Next-state and output logic for the move flow.
    always_comb begin
        state_d       = state_q;
        src_sq_d      = src_sq_q;
        dst_sq_d      = dst_sq_q;
        k_d           = k_q;
        src_idx_d     = src_idx_q;
        cap_idx_d     = cap_idx_q;
        cap_valid_d   = cap_valid_q;
        own_block_d   = own_block_q;
        loc_w_d       = loc_w_q;
        loc_b_d       = loc_b_q;
        alive_w_d     = alive_w_q;
        alive_b_d     = alive_b_q;
        player_d      = player_q;
        sel_active_d  = sel_active_q;
        sel_square_d  = sel_square_q;
        move_done_d   = 1'b0;
        move_reject_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enter_p_s) begin
                    src_sq_d = cursor;
                    k_d      = '0;
                    state_d  = S_SCAN_SRC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN_SRC: begin
                if (own_hit_s) begin
                    src_idx_d    = k_q;
                    sel_active_d = 1'b1;
                    sel_square_d = src_sq_q;
                    state_d      = S_SELECTED;
                end else if (k_last_s) begin
                    move_reject_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_SELECTED: begin
                if (esc_p_s || (enter_p_s && (cursor == src_sq_q))) begin
                    sel_active_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (enter_p_s) begin
                    dst_sq_d    = cursor;
                    k_d         = '0;
                    cap_valid_d = 1'b0;
                    own_block_d = 1'b0;
                    state_d     = S_SCAN_DST;
                end else if (timeout_s) begin
                    sel_active_d  = 1'b0;
                    move_reject_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_SELECTED;
                end
            end
            S_SCAN_DST: begin
                own_block_d = own_block_q | own_hit_s;
                if (opp_hit_s) begin
                    cap_idx_d   = k_q;
                    cap_valid_d = 1'b1;
                end else begin
                    cap_valid_d = cap_valid_q;
                end
                if (k_last_s) begin
                    if (own_block_q || own_hit_s) begin
                        move_reject_d = 1'b1;
                        state_d       = S_SELECTED;
                    end else begin
                        state_d = S_WAIT_FRAME;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_COMMIT: begin
                if (player_q) begin
                    loc_b_d[int'(src_idx_q)*6 +: 6] = dst_sq_q;
                    if (cap_valid_q) begin
                        alive_w_d[cap_idx_q] = 1'b0;
                    end else begin
                        alive_w_d = alive_w_q;
                    end
                end else begin
                    loc_w_d[int'(src_idx_q)*6 +: 6] = dst_sq_q;
                    if (cap_valid_q) begin
                        alive_b_d[cap_idx_q] = 1'b0;
                    end else begin
                        alive_b_d = alive_b_q;
                    end
                end
                player_d     = ~player_q;
                sel_active_d = 1'b0;
                move_done_d  = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, game-state and registered output updates.
    always_ff @(posedge clk12) begin
        if (reset) begin
            state_q       <= S_IDLE;
            enter_prev_q  <= 1'b0;
            esc_prev_q    <= 1'b0;
            src_sq_q      <= 6'd0;
            dst_sq_q      <= 6'd0;
            k_q           <= '0;
            src_idx_q     <= '0;
            cap_idx_q     <= '0;
            cap_valid_q   <= 1'b0;
            own_block_q   <= 1'b0;
            loc_w_q       <= RST_LOC_W;
            loc_b_q       <= RST_LOC_B;
            alive_w_q     <= '1;
            alive_b_q     <= '1;
            player_q      <= 1'b0;
            sel_active_q  <= 1'b0;
            sel_square_q  <= 6'd0;
            move_done_q   <= 1'b0;
            move_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            enter_prev_q  <= btn_enter;
            esc_prev_q    <= btn_esc;
            src_sq_q      <= src_sq_d;
            dst_sq_q      <= dst_sq_d;
            k_q           <= k_d;
            src_idx_q     <= src_idx_d;
            cap_idx_q     <= cap_idx_d;
            cap_valid_q   <= cap_valid_d;
            own_block_q   <= own_block_d;
            loc_w_q       <= loc_w_d;
            loc_b_q       <= loc_b_d;
            alive_w_q     <= alive_w_d;
            alive_b_q     <= alive_b_d;
            player_q      <= player_d;
            sel_active_q  <= sel_active_d;
            sel_square_q  <= sel_square_d;
            move_done_q   <= move_done_d;
            move_reject_q <= move_reject_d;
        end
    end

    assign location_vectors_w = loc_w_q;
    assign location_vectors_b = loc_b_q;
    assign alive_vectors_w    = alive_w_q;
    assign alive_vectors_b    = alive_b_q;
    assign player             = player_q;
    assign sel_active         = sel_active_q;
    assign sel_square         = sel_square_q;
    assign move_done          = move_done_q;
    assign move_reject        = move_reject_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Scoreboard bench for board_move_ctrl: stimulus pushes the expected commit
// or reject into a queue, and a monitor pops and compares on each pulse.
module tb_board_move_ctrl;

    localparam logic [95:0] RST_LW = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] RST_LB = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  cursor = 6'd0;
    logic        btn_enter = 1'b0;
    logic        btn_esc = 1'b0;
    logic        frame_start = 1'b0;
    logic [95:0] location_vectors_w;
    logic [95:0] location_vectors_b;
    logic [15:0] alive_vectors_w;
    logic [15:0] alive_vectors_b;
    logic        player;
    logic        sel_active;
    logic [5:0]  sel_square;
    logic        move_done;
    logic        move_reject;

    board_move_ctrl #(.NUM_PIECES(16), .TIMEOUT_FRAMES(3)) dut (
        .clk12              (clk12),
        .reset              (reset),
        .cursor             (cursor),
        .btn_enter          (btn_enter),
        .btn_esc            (btn_esc),
        .frame_start        (frame_start),
        .location_vectors_w (location_vectors_w),
        .location_vectors_b (location_vectors_b),
        .alive_vectors_w    (alive_vectors_w),
        .alive_vectors_b    (alive_vectors_b),
        .player             (player),
        .sel_active         (sel_active),
        .sel_square         (sel_square),
        .move_done          (move_done),
        .move_reject        (move_reject)
    );

    always #5 clk12 = ~clk12;

    typedef struct {
        logic        is_done;
        logic [95:0] lw;
        logic [95:0] lb;
        logic [15:0] aw;
        logic [15:0] ab;
        logic        pl;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [95:0] m_lw;
    logic [95:0] m_lb;
    logic [15:0] m_aw;
    logic [15:0] m_ab;
    logic        m_pl;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic done);
        exp_t e;
        e.is_done = done;
        e.lw = m_lw;
        e.lb = m_lb;
        e.aw = m_aw;
        e.ab = m_ab;
        e.pl = m_pl;
        exp_q.push_back(e);
    endtask

    // Monitor: every move_done/move_reject pulse must match the next queued expectation.
    always @(negedge clk12) begin
        if (!reset && (move_done || move_reject)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: done=%0b reject=%0b with nothing expected", move_done, move_reject);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_done", {95'd0, move_done}, {95'd0, e.is_done});
                check("pulse_kind_reject", {95'd0, move_reject}, {95'd0, ~e.is_done});
                check("pulse_loc_w", location_vectors_w, e.lw);
                check("pulse_loc_b", location_vectors_b, e.lb);
                check("pulse_alive_w", {80'd0, alive_vectors_w}, {80'd0, e.aw});
                check("pulse_alive_b", {80'd0, alive_vectors_b}, {80'd0, e.ab});
                check("pulse_player", {95'd0, player}, {95'd0, e.pl});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk12);
        reset = 1'b1;
        btn_enter = 1'b0;
        btn_esc = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk12);
        reset = 1'b0;
        m_lw = RST_LW;
        m_lb = RST_LB;
        m_aw = 16'hFFFF;
        m_ab = 16'hFFFF;
        m_pl = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_loc_w"}, location_vectors_w, RST_LW);
        check({tag, "_loc_b"}, location_vectors_b, RST_LB);
        check({tag, "_alive"}, {64'd0, alive_vectors_w, alive_vectors_b}, {64'd0, 32'hFFFF_FFFF});
        check({tag, "_flags"}, {86'd0, player, sel_active, sel_square, move_done, move_reject},
              {86'd0, 10'd0});
    endtask

    task automatic press_enter();
        @(negedge clk12);
        btn_enter = 1'b1;
        @(negedge clk12);
        btn_enter = 1'b0;
    endtask

    task automatic press_esc();
        @(negedge clk12);
        btn_esc = 1'b1;
        @(negedge clk12);
        btn_esc = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk12);
        frame_start = 1'b1;
        @(negedge clk12);
        frame_start = 1'b0;
    endtask

    task automatic wait_sel(input string name, input logic val, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk12);
            if (sel_active == val) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {95'd0, sel_active}, {95'd0, val});
    endtask

    task automatic wait_empty(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk12);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %0d expected pulses still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic select_17();
        cursor = 6'o17;
        press_enter();
        wait_sel("select_17", 1'b1, 20);
        check("select_17_square", {90'd0, sel_square}, {90'd0, 6'o17});
    endtask

    initial begin
        do_reset();
        @(negedge clk12);
        check_reset_state("reset");
        check("reset_slot8_w", {90'd0, location_vectors_w[53:48]}, {90'd0, 6'o17});

        // Plain move: white pawn slot 8 from 17 to 37.
        select_17();
        cursor = 6'o37;
        m_lw[53:48] = 6'o37;
        m_pl = 1'b1;
        push_exp(1'b1);
        press_enter();
        repeat (20) @(negedge clk12);
        check("hold_before_frame", location_vectors_w, RST_LW);
        pulse_frame();
        wait_empty("move_commit", 10);
        check("after_move_w8", {90'd0, location_vectors_w[53:48]}, {90'd0, 6'o37});
        check("after_move_flags", {94'd0, player, sel_active}, {94'd0, 2'b10});

        // Empty source square is rejected.
        do_reset();
        cursor = 6'o33;
        push_exp(1'b0);
        press_enter();
        wait_empty("empty_src_reject", 25);
        check("empty_src_sel", {95'd0, sel_active}, 96'd0);

        // Own-piece destination is rejected, selection kept; then a capture.
        do_reset();
        select_17();
        cursor = 6'o07;
        push_exp(1'b0);
        press_enter();
        wait_empty("own_block_reject", 25);
        check("own_block_sel", {89'd0, sel_active, sel_square}, {89'd0, 1'b1, 6'o17});
        cursor = 6'o67;
        m_lw[53:48] = 6'o67;
        m_ab = 16'hFEFF;
        m_pl = 1'b1;
        push_exp(1'b1);
        press_enter();
        repeat (20) @(negedge clk12);
        pulse_frame();
        wait_empty("capture_commit", 10);
        check("capture_alive_b", {80'd0, alive_vectors_b}, {80'd0, 16'hFEFF});
        check("capture_w8", {90'd0, location_vectors_w[53:48]}, {90'd0, 6'o67});

        // Esc cancels; Enter+Esc together also cancels; held Enter selects once.
        do_reset();
        select_17();
        press_esc();
        wait_sel("esc_cancel", 1'b0, 5);
        select_17();
        cursor = 6'o37;
        @(negedge clk12);
        btn_enter = 1'b1;
        btn_esc = 1'b1;
        @(negedge clk12);
        btn_enter = 1'b0;
        btn_esc = 1'b0;
        wait_sel("both_cancel", 1'b0, 5);
        pulse_frame();
        repeat (25) @(negedge clk12);
        check("both_no_move", location_vectors_w, RST_LW);
        cursor = 6'o17;
        @(negedge clk12);
        btn_enter = 1'b1;
        repeat (100) @(negedge clk12);
        btn_enter = 1'b0;
        repeat (3) @(negedge clk12);
        check("held_enter_once", {89'd0, sel_active, sel_square}, {89'd0, 1'b1, 6'o17});
        press_esc();
        wait_sel("held_enter_esc", 1'b0, 5);

        // Reset while waiting for the frame discards the move.
        do_reset();
        select_17();
        cursor = 6'o37;
        press_enter();
        repeat (20) @(negedge clk12);
        do_reset();
        @(negedge clk12);
        check_reset_state("wait_reset");
        pulse_frame();
        repeat (5) @(negedge clk12);
        check("wait_reset_no_move", location_vectors_w, RST_LW);
        check("wait_reset_player", {95'd0, player}, 96'd0);

        // Selection held across three frames.
        do_reset();
        select_17();
`ifdef SELECT_TIMEOUT_EN
        push_exp(1'b0);
        repeat (3) pulse_frame();
        wait_empty("timeout_reject", 10);
        check("timeout_sel", {95'd0, sel_active}, 96'd0);
`else
        repeat (3) pulse_frame();
        repeat (3) @(negedge clk12);
        check("no_timeout_sel", {89'd0, sel_active, sel_square}, {89'd0, 1'b1, 6'o17});
`endif

        repeat (3) @(negedge clk12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
